dmem_responder: RTL and testbench

- Responder side of the CPU data-memory port: accepts load/store requests from the pipeline's MEM stage over a valid/ready handshake.
- Services each request from an internal byte-addressed store after a fixed programmable latency, then returns a response over a second valid/ready handshake.
- Replaces the single-cycle data memory so the pipeline can be exercised against realistic memory stalls.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed programmable latency over valid/ready.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [3:0]    size_q, size_d;
    logic          resp_valid_q, resp_valid_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [7:0]    mem [DEPTH];

    logic          size_ok;
    logic          range_ok;
    logic          align_ok;
    logic          req_err;
    logic          access;
    logic          mem_we;
    logic [64:0]   end_addr;
    logic [AW-1:0] base;
    logic [63:0]   rd_word;

    // 65-bit end address so an all-ones address cannot wrap back into range.
    assign end_addr = {1'b0, addr_q} + {61'd0, size_q};
    assign size_ok  = (size_q == 4'd1) || (size_q == 4'd2) ||
                      (size_q == 4'd4) || (size_q == 4'd8);
    assign range_ok = (end_addr <= 65'(DEPTH));

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_ok = ((addr_q & ({60'd0, size_q} - 64'd1)) == 64'd0);
`else
    assign align_ok = 1'b1;
`endif

    assign req_err = !(size_ok && range_ok && align_ok);
    assign base    = addr_q[AW-1:0];
    assign access  = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we  = access && wr_q && !req_err;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(size_q)) begin
                rd_word[8*i +: 8] = mem[base + AW'(i)];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = CW'(LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    err_d        = req_err;
                    rdata_d      = (req_err || wr_q) ? 64'd0 : rd_word;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Store array has no reset; a reset mid-access leaves state_q in IDLE so mem_we never fires.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(size_q)) begin
                    mem[base + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a byte-array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_size = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  model_mem [DEPTH];

    logic        mon_en = 1'b0;
    logic [63:0] got_rq[$];
    logic        got_eq[$];

    dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && resp_valid === 1'b1) begin
            got_rq.push_back(resp_rdata);
            got_eq.push_back(resp_err);
        end
    end

    function automatic void model_access(input bit w, input logic [63:0] a, input logic [63:0] wd,
                                         input logic [3:0] s, output logic [63:0] rd, output bit e);
        logic [64:0] last;
        int n;
        n    = int'(s);
        last = {1'b0, a} + 65'(n);
        e    = !(n == 1 || n == 2 || n == 4 || n == 8);
        if (!e && last > 65'(DEPTH)) e = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if (!e && (a % 64'(n)) != 0) e = 1'b1;
`endif
        rd = '0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (w) model_mem[int'(a) + i] = wd[8*i +: 8];
                else   rd = rd | (64'(model_mem[int'(a) + i]) << (8 * i));
            end
        end
    endfunction

    task automatic do_req(input bit w, input logic [63:0] a, input logic [63:0] wd, input logic [3:0] s,
                          input int bp, input string nm, output logic [63:0] got_rd, output logic got_e);
        logic [63:0] exp_rd;
        bit          exp_e;
        bit          busy_bad;
        int          lat;
        model_access(w, a, wd, s, exp_rd, exp_e);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = s;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s req_ready before accept: got %b want 1", nm, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom}; req_size = 4'($urandom);
        lat = 0; busy_bad = 1'b0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            if (req_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat != LAT || busy_bad) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d (ready_in_busy=%b) want %0d", nm, lat, busy_bad, LAT);
        end
        repeat (bp) @(posedge clk);
        #1;
        got_rd = resp_rdata; got_e = resp_err;
        tests_run++;
        if (resp_rdata !== exp_rd || resp_err !== exp_e) begin
            tests_failed++;
            $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b", nm, resp_rdata, resp_err, exp_rd, exp_e);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s after handshake: got valid=%b ready=%b want 0/1", nm, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_fill();
        logic [63:0] r; logic e;
        for (int i = 0; i < DEPTH / 8; i++)
            do_req(1'b1, 64'(i * 8), {$urandom, $urandom}, 4'd8, 0, "fill", r, e);
    endtask

    task automatic test_store_load();
        logic [63:0] r; logic e;
        do_req(1'b1, 64'h10, 64'h1122334455667788, 4'd8, 0, "st8", r, e);
        do_req(1'b0, 64'h10, 64'h0, 4'd8, 0, "ld8", r, e);
        tests_run++;
        if (r !== 64'h1122334455667788 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL ld8_const: got %h/%b want 1122334455667788/0", r, e);
        end
    endtask

    task automatic test_subword();
        logic [63:0] r; logic e;
        do_req(1'b1, 64'h11, 64'hAB, 4'd1, 1, "st1", r, e);
        do_req(1'b0, 64'h10, 64'h0, 4'd4, 0, "ld4", r, e);
        tests_run++;
        if (r !== 64'h0000_0000_5566AB88) begin
            tests_failed++;
            $display("FAIL ld4_const: got %h want 000000005566ab88", r);
        end
        do_req(1'b0, 64'h12, 64'h0, 4'd2, 2, "ld2", r, e);
        tests_run++;
        if (r !== 64'h5566) begin
            tests_failed++;
            $display("FAIL ld2_const: got %h want 5566", r);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_rd, r; bit exp_e; logic e; int t;
        model_access(1'b0, 64'h10, 64'h0, 4'd8, exp_rd, exp_e);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (resp_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_err !== exp_e || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got v=%b rd=%h e=%b rdy=%b want 1/%h/%b/0", c, resp_valid, resp_rdata, resp_err, req_ready, exp_rd, exp_e);
            end
            req_valid = 1'($urandom); req_write = 1'b1; req_addr = 64'h10; req_size = 4'd8;
            req_wdata = {$urandom, $urandom};
        end
        @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        t = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) t++;
        end
        tests_run++;
        if (t != 0) begin
            tests_failed++;
            $display("FAIL bp_no_second: got %0d bad cycles want 0", t);
        end
        do_req(1'b0, 64'h10, 64'h0, 4'd8, 0, "bp_recheck", r, e);
    endtask

    task automatic test_errors();
        logic [63:0] r; logic e;
        do_req(1'b0, 64'd1020, 64'h0, 4'd8, 0, "err_range", r, e);
        tests_run++;
        if (e !== 1'b1 || r !== 64'd0) begin
            tests_failed++;
            $display("FAIL err_range_const: got %h/%b want 0/1", r, e);
        end
        do_req(1'b1, 64'h20, {$urandom, $urandom}, 4'd3, 0, "err_size3", r, e);
        tests_run++;
        if (e !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_size3_const: got err=%b want 1", e);
        end
        do_req(1'b0, 64'h20, 64'h0, 4'd8, 0, "size3_unchanged", r, e);
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'd1, 0, "err_wrap", r, e);
        do_req(1'b0, 64'd1016, 64'h0, 4'd8, 0, "last_ok", r, e);
        do_req(1'b0, 64'h14, 64'h0, 4'd8, 0, "misalign", r, e);
        tests_run++;
`ifdef DMEM_ALIGN_CHECK_EN
        if (e !== 1'b1) begin
`else
        if (e !== 1'b0) begin
`endif
            tests_failed++;
            $display("FAIL misalign_err: got err=%b", e);
        end
    endtask

    task automatic test_reset_busy();
        logic [63:0] r; logic e;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_size = 4'd8;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2; reset = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        @(negedge clk); reset = 1'b1;
        do_req(1'b0, 64'h40, 64'h0, 4'd8, 0, "rst_busy_keep", r, e);
    endtask

    task automatic test_random();
        logic [63:0] r, a; logic e;
        logic [3:0] sz;
        int sel;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                8: sz = 4'd3; 9: sz = 4'd0; 10: sz = 4'd5; 11: sz = 4'd15;
                default: sz = 4'(1 << (sel % 4));
            endcase
            case ($urandom_range(0, 7))
                0: a = 64'(DEPTH - int'($urandom_range(0, 8)));
                1: a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, DEPTH - 1));
            endcase
            do_req(1'($urandom), a, {$urandom, $urandom}, sz, int'($urandom_range(0, 3)), "rand", r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_rq[$]; bit exp_eq[$];
        logic [63:0] er, wd; bit ee; bit ok;
        time acc_t [4];
        got_rq.delete(); got_eq.delete();
        resp_ready = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wd = {$urandom, $urandom};
            model_access(k % 2 == 0, 64'(8'h80 + 8 * (k / 2)), wd, 4'd8, er, ee);
            exp_rq.push_back(er); exp_eq.push_back(ee);
            req_valid = 1'b1; req_write = (k % 2 == 0); req_addr = 64'(8'h80 + 8 * (k / 2));
            req_wdata = wd; req_size = 4'd8;
            ok = 1'b0; acc_t[k] = 0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (req_ready === 1'b1) begin
                    @(posedge clk);
                    acc_t[k] = $time;
                    ok = 1'b1;
                    #1;
                end
            end
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL b2b_accept%0d: got no acceptance want accepted", k);
            end
        end
        req_valid = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        mon_en = 1'b0; resp_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tests_run++;
            if ((acc_t[k] - acc_t[k-1]) / 10 != LAT + 2) begin
                tests_failed++;
                $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", k, (acc_t[k] - acc_t[k-1]) / 10, LAT + 2);
            end
        end
        tests_run++;
        if (got_rq.size() != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d responses want 4", got_rq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (got_rq[k] !== exp_rq[k] || got_eq[k] !== exp_eq[k]) begin
                    tests_failed++;
                    $display("FAIL b2b_data%0d: got %h/%b want %h/%b", k, got_rq[k], got_eq[k], exp_rq[k], exp_eq[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_subword();
        test_backpressure();
        test_errors();
        test_reset_busy();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
